// File: rtl/awb_pkg.sv
// Shared constants, state encoding and pixel payload for the auto-white-balance gain controller.
package awb_pkg;

    localparam int unsigned GAIN_W = 16;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned FRAC_W = 8;
    localparam int unsigned DIV_QW = 20;

    localparam logic [GAIN_W-1:0] GAIN_UNITY = 16'd256;

    typedef enum logic [2:0] {
        IDLE,
        DIV_R,
        DIV_B,
        CLAMP,
        APPLY,
        WAIT_VS
    } awb_state_t;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_pix_t;

    // Saturate a divider result into [gmin, gmax]; overflow or divide-by-zero pins to gmax.
    function automatic logic [GAIN_W-1:0] clamp_gain(
        input logic [DIV_QW-1:0] q,
        input logic              ovf,
        input logic [GAIN_W-1:0] gmin,
        input logic [GAIN_W-1:0] gmax
    );
        logic [GAIN_W-1:0] res;
        if (ovf || (q > DIV_QW'(gmax))) begin
            res = gmax;
        end else if (q < DIV_QW'(gmin)) begin
            res = gmin;
        end else begin
            res = GAIN_W'(q);
        end
        return res;
    endfunction

endpackage

// File: rtl/awb_div.sv
// Serial restoring divider: one quotient bit per cycle, DIV_QW cycles after start.
module awb_div
    import awb_pkg::*;
#(
    parameter int unsigned DVD_W = 34,
    parameter int unsigned DVS_W = 26
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DVD_W-1:0]  dividend,
    input  logic [DVS_W-1:0]  divisor,
    output logic              done,
    output logic [DIV_QW-1:0] quotient,
    output logic              overflow
);

    localparam int unsigned ACC_W = DVS_W + DIV_QW;
    localparam int unsigned CNT_W = $clog2(DIV_QW);

    logic [ACC_W-1:0]  rem;
    logic [ACC_W-1:0]  dvs_sh;
    logic [DIV_QW-1:0] q_acc;
    logic [CNT_W-1:0]  cnt;
    logic              active;
    logic              ovf_acc;
    logic              ge_c;
    logic [ACC_W-1:0]  dvs_top_c;

    assign ge_c      = (rem >= dvs_sh);
    assign dvs_top_c = ACC_W'(divisor) << DIV_QW;

    // A start in the same cycle as the final iteration still publishes the finished result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem      <= '0;
            dvs_sh   <= '0;
            q_acc    <= '0;
            cnt      <= '0;
            active   <= 1'b0;
            ovf_acc  <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (active) begin
                if (ge_c) begin
                    rem <= rem - dvs_sh;
                end
                dvs_sh <= dvs_sh >> 1;
                q_acc  <= {q_acc[DIV_QW-2:0], ge_c};
                cnt    <= cnt - CNT_W'(1);
                if (cnt == '0) begin
                    active   <= 1'b0;
                    done     <= 1'b1;
                    quotient <= {q_acc[DIV_QW-2:0], ge_c};
                    overflow <= ovf_acc;
                end
            end
            if (start) begin
                rem     <= ACC_W'(dividend);
                dvs_sh  <= ACC_W'(divisor) << (DIV_QW - 1);
                q_acc   <= '0;
                cnt     <= CNT_W'(DIV_QW - 1);
                active  <= 1'b1;
                ovf_acc <= (divisor == '0) || (ACC_W'(dividend) >= dvs_top_c);
            end
        end
    end

endmodule

// File: rtl/awb_gain_ctrl.sv
// Frame-level gray-world white-balance controller; gains change only at frame boundaries.
module awb_gain_ctrl
    import awb_pkg::*;
#(
    parameter int unsigned       source_h = 512,
    parameter int unsigned       source_v = 512,
    parameter int unsigned       SUM_W    = 26,
    parameter logic [GAIN_W-1:0] GAIN_MAX = 16'd1023,
    parameter logic [GAIN_W-1:0] GAIN_MIN = 16'd64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_vsync,
    input  logic              in_hsync,
    input  logic              in_den,
    input  logic [PIX_W-1:0]  in_data_R,
    input  logic [PIX_W-1:0]  in_data_G,
    input  logic [PIX_W-1:0]  in_data_B,
    input  logic              awb_en,
    input  logic [GAIN_W-1:0] manual_gain_R,
    input  logic [GAIN_W-1:0] manual_gain_B,
    output logic [GAIN_W-1:0] gain_R,
    output logic [GAIN_W-1:0] gain_B,
    output logic              gain_valid,
    output logic              busy,
    output logic              stat_err
);

    localparam int unsigned NPIX   = source_h * source_v;
    localparam int unsigned CNT_W  = $clog2(NPIX + 1);
    localparam int unsigned DVD_W  = SUM_W + FRAC_W;
    localparam int unsigned SEQ_CW = $clog2(DIV_QW);

    logic              vs_q, vs_d, den_q, awb_en_q;
    rgb_pix_t          pix_q;
    logic [GAIN_W-1:0] man_r_q, man_b_q;

    logic [SUM_W-1:0]  sum_r, sum_g, sum_b;
    logic [SUM_W-1:0]  snap_g, snap_b;
    logic [CNT_W-1:0]  pix_cnt;
    logic              seen_fb;

    awb_state_t        state;
    logic [SEQ_CW-1:0] seq_cnt;
    logic [DIV_QW-1:0] q_r;
    logic              ovf_r;
    logic [GAIN_W-1:0] pend_r, pend_b;

    logic              fb_c, stats_ok_c, start_r_c, start_b_c;
    logic [DVD_W-1:0]  div_dividend_c;
    logic [SUM_W-1:0]  div_divisor_c;
    logic              div_done, div_overflow;
    logic [DIV_QW-1:0] div_quotient;
    logic              unused_c;

    assign unused_c = in_hsync;

    // Input retiming stage; every decision below works on the registered copies.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_q     <= 1'b0;
            vs_d     <= 1'b0;
            den_q    <= 1'b0;
            awb_en_q <= 1'b0;
            pix_q    <= '0;
            man_r_q  <= '0;
            man_b_q  <= '0;
        end else begin
            vs_q     <= in_vsync;
            vs_d     <= vs_q;
            den_q    <= in_den;
            awb_en_q <= awb_en;
            pix_q    <= '{r: in_data_R, g: in_data_G, b: in_data_B};
            man_r_q  <= manual_gain_R;
            man_b_q  <= manual_gain_B;
        end
    end

    assign fb_c       = vs_q & ~vs_d;
    assign stats_ok_c = seen_fb & (pix_cnt == CNT_W'(NPIX));
    assign start_r_c  = fb_c & awb_en_q & stats_ok_c;
    assign start_b_c  = ~fb_c & (state == DIV_R) & (seq_cnt == SEQ_CW'(DIV_QW - 1));

    // The red division starts from the live sums at the boundary; blue uses the snapshot.
    assign div_dividend_c = DVD_W'(start_r_c ? sum_g : snap_g) << FRAC_W;
    assign div_divisor_c  = start_r_c ? sum_r : snap_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_r   <= '0;
            sum_g   <= '0;
            sum_b   <= '0;
            pix_cnt <= '0;
        end else if (fb_c) begin
            sum_r   <= '0;
            sum_g   <= '0;
            sum_b   <= '0;
            pix_cnt <= '0;
        end else if (den_q && !vs_q) begin
            sum_r <= sum_r + SUM_W'(pix_q.r);
            sum_g <= sum_g + SUM_W'(pix_q.g);
            sum_b <= sum_b + SUM_W'(pix_q.b);
            if (pix_cnt != '1) begin
                pix_cnt <= pix_cnt + CNT_W'(1);
            end
        end
    end

    awb_div #(
        .DVD_W (DVD_W),
        .DVS_W (SUM_W)
    ) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start_r_c | start_b_c),
        .dividend (div_dividend_c),
        .divisor  (div_divisor_c),
        .done     (div_done),
        .quotient (div_quotient),
        .overflow (div_overflow)
    );

    // Sequencer; a boundary always takes priority and aborts or restarts the running sequence.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            seq_cnt    <= '0;
            seen_fb    <= 1'b0;
            snap_g     <= '0;
            snap_b     <= '0;
            q_r        <= '0;
            ovf_r      <= 1'b0;
            pend_r     <= '0;
            pend_b     <= '0;
            gain_R     <= GAIN_UNITY;
            gain_B     <= GAIN_UNITY;
            gain_valid <= 1'b0;
            busy       <= 1'b0;
            stat_err   <= 1'b0;
        end else begin
            gain_valid <= 1'b0;
            stat_err   <= 1'b0;
            if (fb_c) begin
                seen_fb  <= 1'b1;
                snap_g   <= sum_g;
                snap_b   <= sum_b;
                stat_err <= seen_fb && (pix_cnt != CNT_W'(NPIX));
                seq_cnt  <= '0;
                if (!awb_en_q) begin
                    gain_R     <= man_r_q;
                    gain_B     <= man_b_q;
                    gain_valid <= 1'b1;
                end else if ((state == WAIT_VS) || (state == APPLY)) begin
                    gain_R     <= pend_r;
                    gain_B     <= pend_b;
                    gain_valid <= 1'b1;
                end
                if (start_r_c) begin
                    state <= DIV_R;
                    busy  <= 1'b1;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else begin
                unique case (state)
                    IDLE: ;
                    DIV_R: begin
                        seq_cnt <= seq_cnt + SEQ_CW'(1);
                        if (seq_cnt == SEQ_CW'(DIV_QW - 1)) begin
                            seq_cnt <= '0;
                            state   <= DIV_B;
                        end
                    end
                    DIV_B: begin
                        if (div_done) begin
                            q_r   <= div_quotient;
                            ovf_r <= div_overflow;
                        end
                        seq_cnt <= seq_cnt + SEQ_CW'(1);
                        if (seq_cnt == SEQ_CW'(DIV_QW - 1)) begin
                            seq_cnt <= '0;
                            state   <= CLAMP;
                        end
                    end
                    CLAMP: begin
                        pend_r <= clamp_gain(q_r, ovf_r, GAIN_MIN, GAIN_MAX);
                        pend_b <= clamp_gain(div_quotient, div_overflow, GAIN_MIN, GAIN_MAX);
                        state  <= APPLY;
                    end
                    APPLY: begin
                        if (!awb_en_q) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (vs_q) begin
                            gain_R     <= pend_r;
                            gain_B     <= pend_b;
                            gain_valid <= 1'b1;
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end else begin
                            state <= WAIT_VS;
                        end
                    end
                    WAIT_VS: begin
                        if (!awb_en_q) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_awb_gain_ctrl.sv
// Directed bench for awb_gain_ctrl on a 4x4 source with hand-computed gains and event timing.
module tb_awb_gain_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_vsync, in_hsync, in_den;
    logic [7:0]  in_data_R, in_data_G, in_data_B;
    logic        awb_en;
    logic [15:0] manual_gain_R, manual_gain_B;
    logic [15:0] gain_R, gain_B;
    logic        gain_valid, busy, stat_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_fb = 0;
    int gv_cnt, gv_first, gv_last, g_r_first, g_b_first, g_r_last, g_b_last;
    int busy_cnt, busy_first, busy_last, err_cnt, err_first, unstable;
    int prev_r, prev_b;

    awb_gain_ctrl #(
        .source_h (4),
        .source_v (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_vsync      (in_vsync),
        .in_hsync      (in_hsync),
        .in_den        (in_den),
        .in_data_R     (in_data_R),
        .in_data_G     (in_data_G),
        .in_data_B     (in_data_B),
        .awb_en        (awb_en),
        .manual_gain_R (manual_gain_R),
        .manual_gain_B (manual_gain_B),
        .gain_R        (gain_R),
        .gain_B        (gain_B),
        .gain_valid    (gain_valid),
        .busy          (busy),
        .stat_err      (stat_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rel(input int x);
        return (x < 0) ? -1 : x - t_fb;
    endfunction

    task automatic clear_stats();
        gv_cnt = 0; gv_first = -1; gv_last = -1;
        g_r_first = -1; g_b_first = -1; g_r_last = -1; g_b_last = -1;
        busy_cnt = 0; busy_first = -1; busy_last = -1;
        err_cnt = 0; err_first = -1; unstable = 0;
        prev_r = int'(gain_R); prev_b = int'(gain_B);
    endtask

    // One clock; outputs sampled 1 ns after the edge and folded into the running statistics.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (gain_valid) begin
            gv_cnt++;
            if (gv_first < 0) begin
                gv_first = cyc; g_r_first = int'(gain_R); g_b_first = int'(gain_B);
            end
            gv_last = cyc; g_r_last = int'(gain_R); g_b_last = int'(gain_B);
        end else if (int'(gain_R) != prev_r || int'(gain_B) != prev_b) begin
            unstable++;
        end
        prev_r = int'(gain_R); prev_b = int'(gain_B);
        if (busy) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
        end
        if (stat_err) begin
            err_cnt++;
            if (err_first < 0) err_first = cyc;
        end
    endtask

    task automatic watch(input int n);
        repeat (n) step();
    endtask

    // Active frame of 4 lines x 4 pixels (first npix with den), then vsync rises; returns at T.
    task automatic frame(input int r, input int g, input int b, input int npix);
        clear_stats();
        in_vsync = 1'b0;
        for (int ln = 0; ln < 4; ln++) begin
            for (int px = 0; px < 4; px++) begin
                in_den = ((ln * 4 + px) < npix);
                in_data_R = 8'(r); in_data_G = 8'(g); in_data_B = 8'(b);
                step();
            end
            in_den = 1'b0; in_hsync = 1'b1;
            step();
            in_hsync = 1'b0;
            repeat (7) step();
        end
        in_vsync = 1'b1;
        step();
        t_fb = cyc;
    endtask

    task automatic expect_auto(input string tag, input int er, input int eb);
        check_eq({tag, "_gv_at"}, rel(gv_first), 43);
        check_eq({tag, "_gv_cnt"}, gv_cnt, 1);
        check_eq({tag, "_gain_r"}, g_r_first, er);
        check_eq({tag, "_gain_b"}, g_b_first, eb);
        check_eq({tag, "_busy_first"}, rel(busy_first), 1);
        check_eq({tag, "_busy_last"}, rel(busy_last), 42);
        check_eq({tag, "_busy_cnt"}, busy_cnt, 42);
        check_eq({tag, "_err_cnt"}, err_cnt, 0);
        check_eq({tag, "_stable"}, unstable, 0);
    endtask

    initial begin
        reset_n = 1'b0; in_vsync = 1'b0; in_hsync = 1'b0; in_den = 1'b0;
        in_data_R = 8'd0; in_data_G = 8'd0; in_data_B = 8'd0;
        awb_en = 1'b1; manual_gain_R = 16'd0; manual_gain_B = 16'd0;
        clear_stats();
        repeat (3) step();
        check_eq("rst_gain_r", int'(gain_R), 256);
        check_eq("rst_gain_b", int'(gain_B), 256);
        check_eq("rst_gv", int'(gain_valid), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_err", int'(stat_err), 0);
        reset_n = 1'b1;
        step();

        // first boundary after reset is discarded silently, second one computes unity gains
        frame(100, 100, 100, 16); watch(60);
        check_eq("s1_first_gv_cnt", gv_cnt, 0);
        check_eq("s1_first_busy", busy_cnt, 0);
        check_eq("s1_first_err", err_cnt, 0);
        check_eq("s1_first_gain_r", int'(gain_R), 256);
        frame(100, 100, 100, 16); watch(60);
        expect_auto("s1", 256, 256);

        frame(50, 100, 200, 16); watch(60);
        expect_auto("s2", 512, 128);

        frame(0, 80, 255, 16); watch(60);
        expect_auto("s3", 1023, 80);

        // manual mode: sampled at the boundary, applied one cycle later, unclamped
        awb_en = 1'b0; manual_gain_R = 16'd300; manual_gain_B = 16'd200;
        frame(100, 100, 100, 16); watch(60);
        check_eq("s4_gv_at", rel(gv_first), 1);
        check_eq("s4_gv_cnt", gv_cnt, 1);
        check_eq("s4_gain_r", g_r_first, 300);
        check_eq("s4_gain_b", g_b_first, 200);
        check_eq("s4_busy", busy_cnt, 0);
        manual_gain_R = 16'd500; manual_gain_B = 16'd500;
        frame(100, 100, 100, 16);
        check_eq("s4_hold_r", int'(gain_R), 300);
        check_eq("s4_hold_b", int'(gain_B), 200);
        check_eq("s4_hold_stable", unstable, 0);
        watch(60);
        check_eq("s4b_gv_at", rel(gv_first), 1);
        check_eq("s4b_gain_r", g_r_first, 500);
        check_eq("s4b_gain_b", g_b_first, 500);

        // short frame: statistics discarded with a stat_err pulse
        awb_en = 1'b1;
        frame(60, 60, 60, 15); watch(60);
        check_eq("s5_err_at", rel(err_first), 1);
        check_eq("s5_err_cnt", err_cnt, 1);
        check_eq("s5_gv_cnt", gv_cnt, 0);
        check_eq("s5_busy", busy_cnt, 0);
        check_eq("s5_gain_r", int'(gain_R), 500);
        check_eq("s5_gain_b", int'(gain_B), 500);

        // short blanking: result parks until the next boundary, which starts its own sequence
        frame(50, 100, 200, 16); watch(10);
        check_eq("s6_early_gv", gv_cnt, 0);
        frame(0, 80, 255, 16);
        check_eq("s6_hold_r", int'(gain_R), 500);
        check_eq("s6_hold_gv", gv_cnt, 0);
        check_eq("s6_busy_wait", int'(busy), 1);
        watch(60);
        check_eq("s6_pend_at", rel(gv_first), 1);
        check_eq("s6_pend_r", g_r_first, 512);
        check_eq("s6_pend_b", g_b_first, 128);
        check_eq("s6_next_at", rel(gv_last), 43);
        check_eq("s6_next_r", g_r_last, 1023);
        check_eq("s6_next_b", g_b_last, 80);
        check_eq("s6_gv_cnt", gv_cnt, 2);
        check_eq("s6_stable", unstable, 0);

        // asynchronous reset in the middle of the red division
        frame(100, 100, 100, 16); watch(10);
        check_eq("s7_busy_pre", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        check_eq("s7_rst_r", int'(gain_R), 256);
        check_eq("s7_rst_b", int'(gain_B), 256);
        check_eq("s7_rst_busy", int'(busy), 0);
        check_eq("s7_rst_gv", int'(gain_valid), 0);
        step(); step();
        reset_n = 1'b1;
        clear_stats();
        watch(60);
        check_eq("s7_post_gv", gv_cnt, 0);
        check_eq("s7_post_err", err_cnt, 0);
        check_eq("s7_post_busy", busy_cnt, 0);
        frame(50, 100, 200, 16); watch(60);
        expect_auto("s7_recover", 512, 128);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/awb_gain_ctrl.md
Name: awb_gain_ctrl

Overview:
Frame-level auto-white-balance controller for the colour-correction gain stage.
- Accumulates per-channel R/G/B sums over each active frame and computes gray-world gains gain_R = G/R and gain_B = G/B, in 8.8 fixed point (256 = 1.0).
- Applies new gains only at frame boundaries, so the gain stage never changes mid-frame.
- Sits beside the gain stage, on the same pixel bus, ahead of it in the pipeline.

Parameters:
source_h, 512, active pixels per line
source_v, 512, active lines per frame
SUM_W, 26, accumulator width (must hold source_h*source_v*255)
GAIN_MAX, 16'd1023, upper gain clamp (~4.0)
GAIN_MIN, 16'd64, lower gain clamp (0.25)

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
in_vsync  in  1  frame sync, active high (high = vertical blanking)
in_hsync  in  1  line sync (not used for statistics)
in_den  in  1  pixel valid
in_data_R  in  8  red pixel
in_data_G  in  8  green pixel
in_data_B  in  8  blue pixel
awb_en  in  1  1 = automatic gains, 0 = manual gains
manual_gain_R  in  16  manual red gain, 8.8
manual_gain_B  in  16  manual blue gain, 8.8
gain_R  out  16  applied red gain, 8.8
gain_B  out  16  applied blue gain, 8.8
gain_valid  out  1  one-cycle pulse when the gains update
busy  out  1  divider sequence in progress
stat_err  out  1  one-cycle pulse when a frame's statistics are discarded

Behaviour:
- Reset (async, reset_n=0) forces:
  - gain_R = gain_B = 256; gain_valid = busy = stat_err = 0
  - accumulators, pixel counter, first_frame flag, pending registers and FSM (IDLE) cleared
- All inputs are registered once. A frame boundary (FB) is the registered in_vsync rising edge.
- Accumulation:
  - When registered den=1 and vsync=0: add the pixel to sum_R, sum_G and sum_B (SUM_W bits each) and increment pix_cnt.
  - den while vsync=1 is ignored.
- At FB cycle T:
  - Snapshot the sums and pix_cnt; clear the accumulators in the same cycle.
  - If first_frame (first FB after reset) or pix_cnt != source_h*source_v: discard the snapshot, pulse stat_err at T+1 (mismatch case only; first_frame discards silently) and stay IDLE. first_frame clears at the first FB.
  - Otherwise, with awb_en=1, enter DIV_R.
- FSM states and transitions:
  - IDLE: wait for a valid FB.
  - DIV_R: 20 cycles (T+1..T+20) computing (sum_G<<8)/sum_R.
  - DIV_B: 20 cycles (T+21..T+40) computing (sum_G<<8)/sum_B.
  - CLAMP: T+41; results go to pend_R/pend_B.
  - APPLY: T+42; if registered vsync is still 1, outputs update at T+43 with gain_valid=1; else go to WAIT_VS.
  - WAIT_VS: hold until the next FB, then apply pend first in that cycle. That FB then starts its own sequence as usual.
  - busy=1 in all states except IDLE.
- Division rules:
  - Restoring divider, 20-bit quotient, one bit per cycle.
  - Clamp the result to [GAIN_MIN, GAIN_MAX].
  - Divisor 0 or quotient overflow (>= 2^20) gives GAIN_MAX.
- Manual mode (awb_en=0):
  - manual_gain_R/B are sampled at each FB and output at FB+1 with gain_valid=1; no clamp.
  - Accumulation continues. A sequence already running when awb_en falls completes, but its result is dropped.
- A new FB while busy (frame shorter than ~45 cycles of blanking + active): abort the running sequence, keep the current outputs, and start on the new snapshot.
- Gains never change outside a gain_valid cycle.

Decomposition:
- Package awb_pkg:
  - GAIN_UNITY = 16'd256, DIV_QW = 20
  - FSM state encoding (IDLE, DIV_R, DIV_B, CLAMP, APPLY, WAIT_VS)
  - Gain width 16
- One sub-module, awb_div:
  - Serial restoring divider: start/done handshake, dividend/divisor in, quotient + overflow out.
  - Instantiated once and reused sequentially for R and B.

Test Plan:
All scenarios use source_h=4, source_v=4, long blanking.
1. Reset, then two full gray frames of (100,100,100) → first FB discarded (no gain_valid); second FB → gain_R = gain_B = 256, gain_valid at T+43, busy high T+1..T+42.
2. Frame of (50,100,200) after a warm-up frame → gain_R = 512, gain_B = 128.
3. Frame with R=0, G=80, B=255 → gain_R = 1023 (GAIN_MAX), gain_B = 80 (clamp not hit).
4. awb_en=0, manual gains 300/200 → gain_R = 300, gain_B = 200 at FB+1 with gain_valid; unchanged mid-frame when the manual inputs change.
5. Frame with 15 den pixels → stat_err pulse at T+1, gains unchanged, busy stays 0.
6. Assert reset_n=0 at T+10 (mid DIV_R) → immediate gains 256, busy 0; the next FB is treated as first_frame.
